// File: rtl/param_regs.sv
// Picture/cursor parameter register bank: command pulses edit a working copy,
// which is copied to the output (shadow) registers once per frame on the vs rising edge.
module param_regs #(
    parameter int          STEP_B = 8,
    parameter int          STEP_G = 2,
    parameter int          STEP_C = 4,
    parameter logic [19:0] REPEAT = 20'd500000,
    parameter logic [12:0] colMax = 13'd640,
    parameter logic [12:0] rowMax = 13'd480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vs,
    input  logic              binc,
    input  logic              bdec,
    input  logic              cinc,
    input  logic              cdec,
    input  logic              sinc,
    input  logic              sdec,
    input  logic [3:0]        gauss_sel,
    input  logic [3:0]        clr_sel,
    input  logic [3:0]        gs_bg_sel,
    input  logic [3:0]        move,
    input  logic [3:0]        size,
    input  logic [1:0]        mode,
    output logic signed [7:0] bright,
    output logic [7:0]        contrast,
    output logic [7:0]        sat,
    output logic [1:0]        gauss_lvl,
    output logic [1:0]        clr_idx,
    output logic [1:0]        bg_idx,
    output logic [9:0]        cur_x,
    output logic [8:0]        cur_y,
    output logic [6:0]        cur_w,
    output logic [6:0]        cur_h,
    output logic              cur_en,
    output logic [1:0]        cur_style,
    output logic              upd
);

    localparam logic [19:0] REP_LAST = 20'(REPEAT - 20'd1);

    // MV_LOCKED: move must return to zero before the next press counts.
    typedef enum logic [1:0] {
        MV_LOCKED = 2'd0,
        MV_ARMED  = 2'd1,
        MV_REPEAT = 2'd2
    } mv_state_t;

    mv_state_t          mv_state;
    logic [19:0]        rep_cnt;
    logic               vs_q;
    logic               vs_edge;
    logic               move_step;

    logic signed [7:0]  w_bright;
    logic [7:0]         w_contrast, w_sat;
    logic [1:0]         w_gauss, w_clr, w_bg;
    logic [9:0]         w_x;
    logic [8:0]         w_y;
    logic [6:0]         w_w, w_h;
    logic               w_en;
    logic [1:0]         w_style;

    logic signed [7:0]  n_bright;
    logic [7:0]         n_contrast, n_sat;
    logic [1:0]         n_gauss, n_clr, n_bg;
    logic [9:0]         n_x;
    logic [8:0]         n_y;
    logic [6:0]         n_w, n_h;

    function automatic logic signed [7:0] bright_step(input logic signed [7:0] v,
                                                     input logic inc, input logic dec);
        int t;
        t = int'(v);
        if (inc && !dec) t = t + STEP_B;
        if (dec && !inc) t = t - STEP_B;
        if (t > 127)  t = 127;
        if (t < -128) t = -128;
        return 8'(t);
    endfunction

    function automatic logic [7:0] gain_step(input logic [7:0] v, input logic inc, input logic dec);
        int t;
        t = int'(v);
        if (inc && !dec) t = t + STEP_G;
        if (dec && !inc) t = t - STEP_G;
        if (t > 64) t = 64;
        if (t < 4)  t = 4;
        return 8'(t);
    endfunction

    function automatic logic [6:0] size_step(input logic [6:0] v, input logic inc, input logic dec);
        int t;
        t = int'(v);
        if (inc && !dec) t = t + 4;
        if (dec && !inc) t = t - 4;
        if (t > 64) t = 64;
        if (t < 4)  t = 4;
        return 7'(t);
    endfunction

    // Highest set bit wins; bit3 maps to index 0.
    function automatic logic [1:0] sel_idx(input logic [3:0] s, input logic [1:0] cur);
        logic [1:0] r;
        casez (s)
            4'b1???: r = 2'd0;
            4'b01??: r = 2'd1;
            4'b001?: r = 2'd2;
            4'b0001: r = 2'd3;
            default: r = cur;
        endcase
        return r;
    endfunction

    // Moves position by one step in the requested direction, then clamps against
    // the (possibly just resized) cursor so a size change re-clamps in the same update.
    function automatic int axis_step(input int pos, input logic plus, input logic minus,
                                     input logic step, input int lim);
        int t;
        t = pos;
        if (step && plus && !minus) t = t + STEP_C;
        if (step && minus && !plus) t = t - STEP_C;
        if (t > lim) t = lim;
        if (t < 0)   t = 0;
        return t;
    endfunction

    assign vs_edge   = vs & ~vs_q;
    assign move_step = (move != 4'h0) &&
                       ((mv_state == MV_ARMED) ||
                        (mv_state == MV_REPEAT && rep_cnt == REP_LAST));

    always_comb begin
        n_bright   = bright_step(w_bright, binc, bdec);
        n_contrast = gain_step(w_contrast, cinc, cdec);
        n_sat      = gain_step(w_sat, sinc, sdec);
        n_gauss    = sel_idx(gauss_sel, w_gauss);
        n_clr      = sel_idx(clr_sel, w_clr);
        n_bg       = sel_idx(gs_bg_sel, w_bg);
        n_w        = size_step(w_w, size[3], size[2]);
        n_h        = size_step(w_h, size[1], size[0]);
        n_x        = 10'(axis_step(int'(w_x), move[0], move[3], move_step,
                                   int'(colMax) - int'(n_w)));
        n_y        = 9'(axis_step(int'(w_y), move[1], move[2], move_step,
                                  int'(rowMax) - int'(n_h)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mv_state <= MV_LOCKED;
            rep_cnt  <= '0;
        end else if (move == 4'h0) begin
            mv_state <= MV_ARMED;
            rep_cnt  <= '0;
        end else begin
            case (mv_state)
                MV_ARMED: begin
                    mv_state <= MV_REPEAT;
                    rep_cnt  <= '0;
                end
                MV_REPEAT: rep_cnt <= (rep_cnt == REP_LAST) ? 20'd0 : rep_cnt + 20'd1;
                default:   rep_cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q       <= 1'b0;
            w_bright   <= 8'sd0;
            w_contrast <= 8'h10;
            w_sat      <= 8'h10;
            w_gauss    <= 2'd0;
            w_clr      <= 2'd0;
            w_bg       <= 2'd0;
            w_x        <= 10'd312;
            w_y        <= 9'd232;
            w_w        <= 7'd16;
            w_h        <= 7'd16;
            w_en       <= 1'b0;
            w_style    <= 2'd0;
        end else begin
            vs_q       <= vs;
            w_bright   <= n_bright;
            w_contrast <= n_contrast;
            w_sat      <= n_sat;
            w_gauss    <= n_gauss;
            w_clr      <= n_clr;
            w_bg       <= n_bg;
            w_x        <= n_x;
            w_y        <= n_y;
            w_w        <= n_w;
            w_h        <= n_h;
            w_en       <= w_en ^ mode[0];
            w_style    <= w_style + {1'b0, mode[1]};
        end
    end

    // Shadow copy takes the pre-command working values when a command shares the vs edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            upd       <= 1'b0;
            bright    <= 8'sd0;
            contrast  <= 8'h10;
            sat       <= 8'h10;
            gauss_lvl <= 2'd0;
            clr_idx   <= 2'd0;
            bg_idx    <= 2'd0;
            cur_x     <= 10'd312;
            cur_y     <= 9'd232;
            cur_w     <= 7'd16;
            cur_h     <= 7'd16;
            cur_en    <= 1'b0;
            cur_style <= 2'd0;
        end else begin
            upd <= vs_edge;
            if (vs_edge) begin
                bright    <= w_bright;
                contrast  <= w_contrast;
                sat       <= w_sat;
                gauss_lvl <= w_gauss;
                clr_idx   <= w_clr;
                bg_idx    <= w_bg;
                cur_x     <= w_x;
                cur_y     <= w_y;
                cur_w     <= w_w;
                cur_h     <= w_h;
                cur_en    <= w_en;
                cur_style <= w_style;
            end
        end
    end

endmodule

// File: tb/tb_param_regs.sv
// Directed bench for param_regs: each frame pushes the hand-computed shadow contents,
// and a monitor compares them whenever upd fires.
module tb_param_regs;

    typedef struct packed {
        logic [7:0] bright;
        logic [7:0] contrast;
        logic [7:0] sat;
        logic [1:0] gauss;
        logic [1:0] clr;
        logic [1:0] bg;
        logic [9:0] x;
        logic [8:0] y;
        logic [6:0] w;
        logic [6:0] h;
        logic       en;
        logic [1:0] style;
    } exp_t;

    localparam exp_t E_RST = '{bright: 8'h00, contrast: 8'h10, sat: 8'h10, gauss: 2'd0,
                               clr: 2'd0, bg: 2'd0, x: 10'd312, y: 9'd232, w: 7'd16,
                               h: 7'd16, en: 1'b0, style: 2'd0};

    logic clk = 1'b0;
    logic rst, vs, binc, bdec, cinc, cdec, sinc, sdec;
    logic [3:0] gauss_sel, clr_sel, gs_bg_sel, move, size;
    logic [1:0] mode;
    logic signed [7:0] bright;
    logic [7:0] contrast, sat;
    logic [1:0] gauss_lvl, clr_idx, bg_idx, cur_style;
    logic [9:0] cur_x;
    logic [8:0] cur_y;
    logic [6:0] cur_w, cur_h;
    logic cur_en, upd;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    param_regs #(.REPEAT(20'd10)) dut (
        .clk(clk), .rst(rst), .vs(vs), .binc(binc), .bdec(bdec), .cinc(cinc), .cdec(cdec),
        .sinc(sinc), .sdec(sdec), .gauss_sel(gauss_sel), .clr_sel(clr_sel),
        .gs_bg_sel(gs_bg_sel), .move(move), .size(size), .mode(mode), .bright(bright),
        .contrast(contrast), .sat(sat), .gauss_lvl(gauss_lvl), .clr_idx(clr_idx),
        .bg_idx(bg_idx), .cur_x(cur_x), .cur_y(cur_y), .cur_w(cur_w), .cur_h(cur_h),
        .cur_en(cur_en), .cur_style(cur_style), .upd(upd)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(expv));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        exp_q.push_back(e);
        vs = 1'b1;
        tick();
        vs = 1'b0;
        repeat (3) tick();
    endtask

    // Monitor: every upd pulse must match the oldest expected frame and last one cycle.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (upd === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_upd", 32'd1, 32'd0);
                end else begin
                    x = exp_q.pop_front();
                    chk("bright", {{24{bright[7]}}, bright}, {{24{x.bright[7]}}, x.bright});
                    chk("contrast", 32'(contrast), 32'(x.contrast));
                    chk("sat", 32'(sat), 32'(x.sat));
                    chk("gauss_lvl", 32'(gauss_lvl), 32'(x.gauss));
                    chk("clr_idx", 32'(clr_idx), 32'(x.clr));
                    chk("bg_idx", 32'(bg_idx), 32'(x.bg));
                    chk("cur_x", 32'(cur_x), 32'(x.x));
                    chk("cur_y", 32'(cur_y), 32'(x.y));
                    chk("cur_w", 32'(cur_w), 32'(x.w));
                    chk("cur_h", 32'(cur_h), 32'(x.h));
                    chk("cur_en", 32'(cur_en), 32'(x.en));
                    chk("cur_style", 32'(cur_style), 32'(x.style));
                end
                @(negedge clk);
                chk("upd_one_cycle", 32'(upd), 32'd0);
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; vs = 1'b0; binc = 1'b0; bdec = 1'b0; cinc = 1'b0; cdec = 1'b0;
        sinc = 1'b0; sdec = 1'b0; gauss_sel = 4'h0; clr_sel = 4'h0; gs_bg_sel = 4'h0;
        move = 4'h0; size = 4'h0; mode = 2'b00;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_upd", 32'(upd), 32'd0);
        chk("rst_bright", {{24{bright[7]}}, bright}, 32'd0);
        chk("rst_contrast", 32'(contrast), 32'h10);
        chk("rst_cur_x", 32'(cur_x), 32'd312);
        chk("rst_cur_w", 32'(cur_w), 32'd16);
        tick();

        e = E_RST;
        frame();

        // Brightness saturates both ways.
        binc = 1'b1; repeat (17) tick(); binc = 1'b0;
        e.bright = 8'd127;
        frame();
        bdec = 1'b1; repeat (33) tick(); bdec = 1'b0;
        e.bright = 8'h80;
        frame();

        // Opposing gain commands cancel; sat clamps at 0x40.
        cinc = 1'b1; cdec = 1'b1; tick(); cinc = 1'b0; cdec = 1'b0;
        frame();
        sinc = 1'b1; repeat (30) tick(); sinc = 1'b0;
        e.sat = 8'h40;
        frame();

        gauss_sel = 4'b0110; clr_sel = 4'b0001; gs_bg_sel = 4'b0010; tick();
        gauss_sel = 4'h0; clr_sel = 4'h0; gs_bg_sel = 4'h0;
        e.gauss = 2'd1; e.clr = 2'd3; e.bg = 2'd2;
        frame();

        // Held move with auto-repeat every 10 cycles: steps at 0, 10, 20, 30.
        move = 4'b0001; repeat (35) tick(); move = 4'h0; tick();
        e.x = 10'd328;
        frame();
        move = 4'b1001; repeat (35) tick(); move = 4'h0; tick();
        move = 4'b0011; tick(); move = 4'h0; tick();
        e.x = 10'd332; e.y = 9'd236;
        frame();

        // Run right into the edge: 640 - 16 = 624.
        move = 4'b0001; repeat (1000) tick(); move = 4'h0; tick();
        mode = 2'b01; tick(); mode = 2'b10; tick(); tick(); mode = 2'b00;
        e.x = 10'd624; e.en = 1'b1; e.style = 2'd2;
        frame();

        // Widening at the edge pulls cur_x back; height saturates at 4.
        size = 4'b1000; tick();
        size = 4'b0001; repeat (4) tick(); size = 4'h0;
        e.w = 7'd20; e.x = 10'd620; e.h = 7'd4;
        frame();

        // Reset while move held: no stepping until released and pressed again.
        move = 4'b0001; repeat (5) tick();
        rst = 1'b1; repeat (2) tick(); rst = 1'b0;
        repeat (30) tick();
        move = 4'h0; tick();
        e = E_RST;
        frame();
        move = 4'b0001; tick(); move = 4'h0; tick();
        e.x = 10'd316;
        frame();

        // Command on the vs edge lands one frame later.
        exp_q.push_back(e);
        binc = 1'b1; vs = 1'b1; tick(); binc = 1'b0; vs = 1'b0;
        repeat (3) tick();
        e.bright = 8'd8;
        frame();

        repeat (5) tick();
        chk("frames_pending", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
